// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter between pipeline writeback (WB) and the multiply/divide unit (MD),
// with starvation protection for MD and a busy scoreboard of in-flight MD destinations.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        WbWrite,
  input  logic [4:0]  WbReg,
  input  logic [31:0] WbData,
  input  logic        MdValid,
  input  logic [4:0]  MdReg,
  input  logic [31:0] MdData,
  output logic        MdReady,
  input  logic        MdIssue,
  input  logic [4:0]  MdIssueReg,
  input  logic [4:0]  QueryReg1,
  input  logic [4:0]  QueryReg2,
  output logic        Hazard1,
  output logic        Hazard2,
  output logic        WbStall,
  output logic        WbDrop,
  output logic        RegWrite,
  output logic [4:0]  WriteReg,
  output logic [31:0] WriteData
);

  typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [31:0]       busy_q, busy_d;
  logic              reg_write_q, reg_write_d;
  logic [4:0]        write_reg_q, write_reg_d;
  logic [31:0]       write_data_q, write_data_d;
  logic              wb_drop_q, wb_drop_d;
  logic              grant_md, grant_wb;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      busy_q       <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      wb_drop_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      wb_drop_q    <= wb_drop_d;
    end
  end

  assign cnt_inc = cnt_q + 1'b1;

  // The counter tracks consecutive cycles MD lost to WB; reaching the limit forces one MD grant.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_md  = 1'b0;
    grant_wb  = 1'b0;
    wb_drop_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (MdValid && !WbWrite) begin
          grant_md = 1'b1;
        end else if (MdValid) begin
          grant_wb = 1'b1;
          cnt_d    = CNT_W'(1);
          state_d  = (STARVE_LIMIT == 1) ? FORCE : WAIT;
        end else begin
          grant_wb = WbWrite;
        end
      end
      WAIT: begin
        if (!MdValid) begin
          grant_wb = WbWrite;
          cnt_d    = '0;
          state_d  = IDLE;
        end else if (!WbWrite) begin
          grant_md = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          grant_wb = 1'b1;
          cnt_d    = cnt_inc;
          if (cnt_inc == LIMIT) state_d = FORCE;
        end
      end
      FORCE: begin
        grant_md  = MdValid;
        wb_drop_d = WbWrite;
        cnt_d     = '0;
        state_d   = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Register 0 still completes its grant but never raises the write enable or a busy bit.
  always_comb begin
    MdReady      = grant_md;
    WbStall      = (state_q == FORCE);
    Hazard1      = busy_q[QueryReg1] && (QueryReg1 != 5'd0);
    Hazard2      = busy_q[QueryReg2] && (QueryReg2 != 5'd0);
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (grant_md) begin
      reg_write_d  = (MdReg != 5'd0);
      write_reg_d  = MdReg;
      write_data_d = MdData;
    end else if (grant_wb) begin
      reg_write_d  = (WbReg != 5'd0);
      write_reg_d  = WbReg;
      write_data_d = WbData;
    end
    busy_d = busy_q;
    if (grant_md) busy_d[MdReg] = 1'b0;
    if (MdIssue && (MdIssueReg != 5'd0)) busy_d[MdIssueReg] = 1'b1;
  end

  assign RegWrite  = reg_write_q;
  assign WriteReg  = write_reg_q;
  assign WriteData = write_data_q;
  assign WbDrop    = wb_drop_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a loss-counting reference model predicts writes,
// drops and handshakes; a monitor pops expected writes as the DUT presents them.
module tb_regfile_wb_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int CNT_W        = 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        WbWrite = 1'b0;
  logic [4:0]  WbReg = '0;
  logic [31:0] WbData = '0;
  logic        MdValid = 1'b0;
  logic [4:0]  MdReg = '0;
  logic [31:0] MdData = '0;
  logic        MdReady;
  logic        MdIssue = 1'b0;
  logic [4:0]  MdIssueReg = '0;
  logic [4:0]  QueryReg1 = '0;
  logic [4:0]  QueryReg2 = '0;
  logic        Hazard1, Hazard2, WbStall, WbDrop, RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;

  regfile_wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset),
    .WbWrite(WbWrite), .WbReg(WbReg), .WbData(WbData),
    .MdValid(MdValid), .MdReg(MdReg), .MdData(MdData), .MdReady(MdReady),
    .MdIssue(MdIssue), .MdIssueReg(MdIssueReg),
    .QueryReg1(QueryReg1), .QueryReg2(QueryReg2),
    .Hazard1(Hazard1), .Hazard2(Hazard2),
    .WbStall(WbStall), .WbDrop(WbDrop),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        reset;
    logic        wb_write;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        md_valid;
    logic [4:0]  md_reg;
    logic [31:0] md_data;
    logic        md_issue;
    logic [4:0]  issue_reg;
    logic [4:0]  q1;
    logic [4:0]  q2;
  } stim_t;

  typedef struct {
    int          cyc;
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  drop_q[$];
  int  rst_q[$];

  int cyc = 0;
  int vectors = 0;
  int checks = 0;
  int miscompares = 0;
  int start_cyc = 0;
  bit started = 0;
  int stall_cnt = 0;

  // Reference model: count of consecutive cycles MD has lost; at the limit MD is forced through.
  int losses = 0;
  bit busy[32];
  bit last_ready = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  // Monitor: registered write port and drop pulse, compared against the queued predictions.
  always @(posedge Clk) begin
    bit  exp_w, exp_dr;
    wr_t e;
    #1;
    if (started && cyc > start_cyc) begin
      exp_w = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      check("RegWrite", 32'(RegWrite), 32'(exp_w));
      if (exp_w) begin
        e = exp_q.pop_front();
        if (RegWrite) begin
          check("WriteReg", 32'(WriteReg), 32'(e.r));
          check("WriteData", WriteData, e.d);
        end
      end
      exp_dr = (drop_q.size() > 0) && (drop_q[0] == cyc);
      check("WbDrop", 32'(WbDrop), 32'(exp_dr));
      if (exp_dr) void'(drop_q.pop_front());
      if ((rst_q.size() > 0) && (rst_q[0] == cyc)) begin
        void'(rst_q.pop_front());
        check("reset_WriteReg", 32'(WriteReg), 32'd0);
        check("reset_WriteData", WriteData, 32'd0);
      end
    end
  end

  task automatic checkOutput(input stim_t s);
    bit forced, gm, gw, drop;
    forced = (losses >= STARVE_LIMIT);
    gm = s.md_valid && (forced || !s.wb_write);
    last_ready = gm;
    if (started) begin
      check("MdReady", 32'(MdReady), 32'(gm));
      check("WbStall", 32'(WbStall), 32'(forced));
      check("Hazard1", 32'(Hazard1), 32'(busy[s.q1] && s.q1 != 0));
      check("Hazard2", 32'(Hazard2), 32'(busy[s.q2] && s.q2 != 0));
      if (WbStall === 1'b1) stall_cnt++;
    end
    if (s.reset) begin
      losses = 0;
      foreach (busy[i]) busy[i] = 0;
      rst_q.push_back(cyc + 1);
      if (!started) begin
        start_cyc = cyc;
        started = 1;
      end
      return;
    end
    gw = 0;
    drop = 0;
    if (forced) begin
      drop = s.wb_write;
      losses = 0;
    end else if (gm) begin
      losses = 0;
    end else if (s.md_valid) begin
      gw = 1;
      losses++;
    end else begin
      gw = s.wb_write;
      losses = 0;
    end
    if (gm && s.md_reg != 0) exp_q.push_back('{cyc + 1, s.md_reg, s.md_data});
    if (gw && s.wb_reg != 0) exp_q.push_back('{cyc + 1, s.wb_reg, s.wb_data});
    if (drop) drop_q.push_back(cyc + 1);
    if (gm) busy[s.md_reg] = 0;
    if (s.md_issue && s.issue_reg != 0) busy[s.issue_reg] = 1;
  endtask

  task automatic applyStimulus(input stim_t s);
    @(negedge Clk);
    Reset      = s.reset;
    WbWrite    = s.wb_write;
    WbReg      = s.wb_reg;
    WbData     = s.wb_data;
    MdValid    = s.md_valid;
    MdReg      = s.md_reg;
    MdData     = s.md_data;
    MdIssue    = s.md_issue;
    MdIssueReg = s.issue_reg;
    QueryReg1  = s.q1;
    QueryReg2  = s.q2;
    vectors++;
    #1;
    checkOutput(s);
  endtask

  initial begin
    stim_t s;
    bit    md_pend;
    logic [4:0]  md_r;
    logic [31:0] md_d;

    s = idle(); s.reset = 1; applyStimulus(s);
    s = idle(); applyStimulus(s);

    // WB only
    s = idle(); s.wb_write = 1; s.wb_reg = 5; s.wb_data = 32'hDEAD_BEEF; applyStimulus(s);
    s = idle(); applyStimulus(s);

    // MD with a free port, hazard on reg 9 cleared after the handshake
    s = idle(); s.md_issue = 1; s.issue_reg = 9; applyStimulus(s);
    s = idle(); s.md_valid = 1; s.md_reg = 9; s.md_data = -32'sd7; s.q1 = 9; applyStimulus(s);
    s = idle(); s.q1 = 9; applyStimulus(s);

    // Starvation: four WB wins, then one forced MD grant
    s = idle(); s.md_issue = 1; s.issue_reg = 3; applyStimulus(s);
    stall_cnt = 0;
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      s = idle(); s.md_valid = 1; s.md_reg = 3; s.md_data = 32'h1234_5678;
      s.wb_write = 1; s.wb_reg = 5'(10 + i); s.wb_data = 32'hA000_0000 + i; s.q1 = 3;
      applyStimulus(s);
    end
    s = idle(); s.md_valid = 1; s.md_reg = 3; s.md_data = 32'h1234_5678; s.q1 = 3; applyStimulus(s);
    s = idle(); s.q1 = 3; applyStimulus(s);
    check("starve_stall_cycles", 32'(stall_cnt), 32'd1);

    // Register 0 from both sources
    s = idle(); s.md_valid = 1; s.md_reg = 0; s.md_data = 32'h5555_AAAA; applyStimulus(s);
    s = idle(); s.wb_write = 1; s.wb_reg = 0; s.wb_data = 32'h0BAD_F00D; applyStimulus(s);
    s = idle(); applyStimulus(s);

    // Simultaneous set and clear of reg 12
    s = idle(); s.md_issue = 1; s.issue_reg = 12; applyStimulus(s);
    s = idle(); s.md_valid = 1; s.md_reg = 12; s.md_data = 32'd100;
    s.md_issue = 1; s.issue_reg = 12; s.q2 = 12; applyStimulus(s);
    s = idle(); s.q2 = 12; applyStimulus(s);
    s = idle(); s.md_valid = 1; s.md_reg = 12; s.md_data = 32'd200; s.q2 = 12; applyStimulus(s);
    s = idle(); s.q2 = 12; applyStimulus(s);

    // WB write presented while forced: MD wins, WB dropped
    for (int i = 0; i <= STARVE_LIMIT; i++) begin
      s = idle(); s.md_valid = 1; s.md_reg = 7; s.md_data = 32'hCAFE_0007;
      s.wb_write = 1; s.wb_reg = 5'(20 + i); s.wb_data = 32'hB000_0000 + i;
      applyStimulus(s);
    end
    s = idle(); applyStimulus(s);

    // Reset while waiting, with busy bits set
    s = idle(); s.md_issue = 1; s.issue_reg = 4; applyStimulus(s);
    s = idle(); s.md_issue = 1; s.issue_reg = 6; applyStimulus(s);
    for (int i = 0; i < 2; i++) begin
      s = idle(); s.md_valid = 1; s.md_reg = 4; s.md_data = 32'h0000_0044;
      s.wb_write = 1; s.wb_reg = 5'(1 + i); s.wb_data = 32'hC000_0000 + i; s.q1 = 4; s.q2 = 6;
      applyStimulus(s);
    end
    s = idle(); s.reset = 1; s.md_valid = 1; s.md_reg = 4; s.md_data = 32'h0000_0044;
    s.wb_write = 1; s.wb_reg = 3; s.wb_data = 32'hC000_0003; s.q1 = 4; s.q2 = 6; applyStimulus(s);
    s = idle(); s.q1 = 4; s.q2 = 6; applyStimulus(s);
    s = idle(); s.md_valid = 1; s.md_reg = 4; s.md_data = 32'h0000_0044; applyStimulus(s);
    s = idle(); applyStimulus(s);

    // Randomized traffic from an MD unit that holds its result until accepted
    md_pend = 0;
    md_r = '0;
    md_d = '0;
    for (int n = 0; n < 2000; n++) begin
      if (!md_pend && ($urandom_range(0, 3) == 0)) begin
        md_pend = 1;
        md_r = 5'($urandom_range(0, 7));
        md_d = $urandom;
      end
      s = idle();
      s.reset     = ($urandom_range(0, 199) == 0);
      s.md_valid  = md_pend;
      s.md_reg    = md_r;
      s.md_data   = md_d;
      s.wb_write  = (losses >= STARVE_LIMIT) ? ($urandom_range(0, 9) == 0)
                                             : ($urandom_range(0, 9) < 7);
      s.wb_reg    = 5'($urandom_range(0, 31));
      s.wb_data   = $urandom;
      s.md_issue  = ($urandom_range(0, 3) == 0);
      s.issue_reg = 5'($urandom_range(0, 7));
      s.q1        = 5'($urandom_range(0, 7));
      s.q2        = 5'($urandom_range(0, 7));
      applyStimulus(s);
      if (last_ready && !s.reset) md_pend = 0;
    end

    for (int i = 0; i < 3; i++) begin
      s = idle(); applyStimulus(s);
    end
    @(posedge Clk);
    #2;
    check("pending_writes_left", 32'(exp_q.size()), 32'd0);
    check("pending_drops_left", 32'(drop_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between the in-order pipeline writeback (WB) and the multicycle multiply/divide unit (MD).
- WB normally has priority and is never back-pressured. MD waits under a valid/ready handshake, with starvation protection that stalls WB for one cycle.
- Keeps a 32-entry busy scoreboard of MD destination registers so decode can detect RAW hazards on in-flight MD results.
- Sits between the WB stage / MD unit and the register file write inputs (RegWrite, WriteReg, WriteData).

Parameters:
- STARVE_LIMIT, 4, number of consecutive cycles MD may lose to WB before WB is forcibly stalled (legal range 1..15).
- CNT_W, 4, width of the starvation counter.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- WbWrite  in  1  pipeline writeback request; always accepted unless WbStall is high.
- WbReg  in  5  WB destination register.
- WbData  in  32  WB write data (signed).
- MdValid  in  1  MD result valid; must hold until MdReady.
- MdReg  in  5  MD destination register.
- MdData  in  32  MD result data (signed).
- MdReady  out  1  MD result accepted this cycle.
- MdIssue  in  1  MD operation issued this cycle.
- MdIssueReg  in  5  destination register of the issued MD operation.
- QueryReg1  in  5  decode source register 1.
- QueryReg2  in  5  decode source register 2.
- Hazard1  out  1  QueryReg1 awaits an MD result.
- Hazard2  out  1  QueryReg2 awaits an MD result.
- WbStall  out  1  pipeline must present no WB write this cycle.
- WbDrop  out  1  registered error pulse: a WB write was dropped.
- RegWrite  out  1  register file write enable.
- WriteReg  out  5  register file write address.
- WriteData  out  32  register file write data (signed).

Behaviour:
- Reset: state IDLE, counter 0, all busy bits 0, RegWrite/WriteReg/WriteData/WbDrop = 0, WbStall = 0.
- Grant is combinational within the cycle. The write-port outputs are registered, so a request granted in cycle N drives RegWrite in cycle N+1, and the register file commits at the following posedge.
- Writes to register 0 are suppressed: RegWrite = 0 on the output cycle, but the handshake/grant still completes and the busy bit is not touched.
- MdReady = MdValid && (state==FORCE || !WbWrite).
- WbStall = (state==FORCE), a pure state decode.
- IDLE:
  - MdValid && !WbWrite: grant MD, stay IDLE.
  - MdValid && WbWrite: grant WB, counter = 1; go to FORCE if STARVE_LIMIT==1, else WAIT.
  - Otherwise: grant WB if WbWrite, else no write.
- WAIT:
  - !MdValid (protocol violation): go to IDLE, counter 0.
  - !WbWrite: grant MD, counter 0, go to IDLE.
  - Else: grant WB, counter+1; go to FORCE when counter+1 == STARVE_LIMIT.
- FORCE:
  - Grant MD if MdValid, then go to IDLE with counter 0.
  - If WbWrite is also high (contract violation), MD still wins, the WB write is discarded, and WbDrop pulses the next cycle.
- Scoreboard:
  - MdIssue with MdIssueReg != 0 sets busy[MdIssueReg].
  - An accepted MD handshake clears busy[MdReg].
  - Set and clear of the same register in the same cycle: set wins.
- Hazard outputs:
  - Hazard1 = busy[QueryReg1] && QueryReg1 != 0; Hazard2 likewise. Both are combinational from registered busy bits.
  - The clear is visible the cycle after the handshake.
- Reset asserted mid-operation (any state): everything returns to reset values at that edge. Pending MD results are not written, and the MD unit must re-present them.

Test Plan:
- WB only: WbWrite=1, WbReg=5, WbData=32'hDEAD_BEEF -> next cycle RegWrite=1, WriteReg=5, WriteData=32'hDEAD_BEEF; MdReady=0 throughout.
- MD with free port: MdIssue reg 9; then MdValid, MdReg=9, MdData=-7, WbWrite=0 -> MdReady=1 the same cycle. Next cycle: WriteReg=9, WriteData=32'hFFFF_FFF9, Hazard1 (QueryReg1=9) drops 0.
- Starvation: MdValid held, WbWrite=1 every cycle, STARVE_LIMIT=4 -> 4 WB grants, then WbStall=1 for exactly one cycle with MD granted, then IDLE.
- Register 0: MdValid, MdReg=0 -> MdReady=1, RegWrite stays 0. WbWrite with WbReg=0 -> RegWrite=0.
- Simultaneous scoreboard: MD handshake on reg 12 and MdIssue reg 12 in the same cycle -> busy[12] remains 1, Hazard2 (QueryReg2=12) stays 1.
- Contract violation / reset: WbWrite=1 in FORCE -> MD written, WbDrop=1 next cycle. Reset in WAIT with busy bits set -> all outputs 0, Hazards 0, MdReady=0 until MdValid is re-presented.
